mac_sequencer: RTL and testbench

- Controller in front of the product-sum MAC datapath (8x8 multiply, 16-bit accumulate, accumulator cleared by its last_input strobe).
- Accepts a stream of (ai, xi) term pairs over a valid/ready handshake.
- Drives the MAC operands and the last_input strobe, and captures each completed sum into an output register with its own valid/ready handshake.
- Also handles idle gaps, term-count limiting, abort/flush and output back-pressure, so upstream logic never touches the MAC directly.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_out_reg.sv | 48 ++++
 rtl/mac_sequencer.sv | 106 ++++++++++
 tb/tb_mac_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer.
// Widths, default term limit and controller states.
package mac_pkg;

   localparam int DATA_W        = 8;
   localparam int SUM_W         = 16;
   localparam int MAX_TERMS_DEF = 16;
   localparam int CNT_W_DEF     = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/mac_out_reg.sv
// Output holding register for completed sums.
// A load in the same cycle as a drain keeps valid high.
module mac_out_reg
   import mac_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [SUM_W-1:0] sum_i,
   input  logic [CNT_W-1:0] terms_i,
   input  logic             trunc_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [SUM_W-1:0] sum_o,
   output logic [CNT_W-1:0] terms_o,
   output logic             trunc_o
);

   logic             valid_q;
   logic [SUM_W-1:0] sum_q;
   logic [CNT_W-1:0] terms_q;
   logic             trunc_q;

   // Capture on load; otherwise drop valid once the consumer takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         terms_q <= '0;
         trunc_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         sum_q   <= sum_i;
         terms_q <= terms_i;
         trunc_q <= trunc_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign terms_o = terms_q;
   assign trunc_o = trunc_q;

endmodule

// File: rtl/mac_sequencer.sv
// Term-stream controller in front of the product-sum MAC.
// Gates operands, closes sums and flushes on abort.
module mac_sequencer
   import mac_pkg::*;
#(
   parameter int MAX_TERMS = MAX_TERMS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_ai,
   input  logic [DATA_W-1:0] in_xi,
   input  logic              in_last,
   input  logic              abort,
   output logic [DATA_W-1:0] mac_ai,
   output logic [DATA_W-1:0] mac_xi,
   output logic              mac_last_input,
   input  logic [SUM_W-1:0]  mac_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_terms,
   output logic              out_trunc,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             close;

   // Abort and a full, undrained output both block new terms.
   assign in_ready = (state_q != ST_FLUSH) && !abort
                   && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign close    = accept && (in_last || cnt_q == LAST_CNT);

   // Idle cycles feed a zero product so the accumulator holds.
   assign mac_ai         = accept ? in_ai : '0;
   assign mac_xi         = accept ? in_xi : '0;
   assign mac_last_input = close || (state_q == ST_FLUSH);
   assign busy           = (state_q != ST_IDLE);

   // State and term counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: flush after abort, close on last or limit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_FLUSH: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         ST_ACCUM: begin
            if (abort) begin
               state_d = ST_FLUSH;
            end else if (close) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (accept) begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (close) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (accept) begin
               state_d = ST_ACCUM;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   mac_out_reg #(
      .CNT_W (CNT_W)
   ) u_out (
      .clk     (clk),
      .reset   (reset),
      .load_i  (close),
      .sum_i   (mac_result),
      .terms_i (cnt_q + CNT_W'(1)),
      .trunc_i (!in_last),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .sum_o   (out_sum),
      .terms_o (out_terms),
      .trunc_o (out_trunc)
   );

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural MAC.
// The DUT runs with a 4-term limit.
module tb_mac_sequencer;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_last, abort;
   logic [7:0]    in_ai, in_xi, mac_ai, mac_xi;
   logic          mac_last_input;
   logic [15:0]   mac_result;
   logic          out_valid, out_ready, out_trunc, busy;
   logic [15:0]   out_sum;
   logic [CW-1:0] out_terms;

   logic [15:0]   acc_q;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Reference MAC: combinational product plus accumulator.
   assign mac_result = acc_q + ({8'd0, mac_ai} * {8'd0, mac_xi});

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               acc_q <= '0;
      else if (mac_last_input) acc_q <= '0;
      else                     acc_q <= mac_result;
   end

   mac_sequencer #(
      .MAX_TERMS (4),
      .CNT_W     (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_ai          (in_ai),
      .in_xi          (in_xi),
      .in_last        (in_last),
      .abort          (abort),
      .mac_ai         (mac_ai),
      .mac_xi         (mac_xi),
      .mac_last_input (mac_last_input),
      .mac_result     (mac_result),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_sum        (out_sum),
      .out_terms      (out_terms),
      .out_trunc      (out_trunc),
      .busy           (busy)
   );

   task automatic send(input logic [7:0] a, input logic [7:0] x,
                       input logic l);
      @(negedge clk);
      in_valid = 1'b1;
      in_ai    = a;
      in_xi    = x;
      in_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_ai    = '0;
         in_xi    = '0;
         in_last  = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 0; in_ai = 0; in_xi = 0;
      in_last = 0; abort = 0; out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_terms !== '0
          || out_trunc !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: v=%0d s=%0d t=%0d tr=%0d b=%0d want 0",
                  out_valid, out_sum, out_terms, out_trunc, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: got %0d want 1", in_ready);
      end
   endtask

   task automatic test_basic;
      send(2, 3, 0);
      send(4, 5, 0);
      send(6, 7, 1);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'd68 || out_terms !== 5'd3
          || out_trunc !== 1'b0) begin
         fails++;
         $display("FAIL basic_sum: v=%0d s=%0d t=%0d tr=%0d want 1/68/3/0",
                  out_valid, out_sum, out_terms, out_trunc);
      end
      idle(1);
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_drain: v=%0d b=%0d want 0/0",
                  out_valid, busy);
      end
   endtask

   task automatic test_gaps;
      send(2, 3, 0);
      idle(3);
      tests++;
      if (mac_result !== 16'd6 || busy !== 1'b1) begin
         fails++;
         $display("FAIL gap_hold1: acc=%0d b=%0d want 6/1",
                  mac_result, busy);
      end
      send(4, 5, 0);
      idle(3);
      tests++;
      if (mac_result !== 16'd26 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL gap_hold2: acc=%0d v=%0d want 26/0",
                  mac_result, out_valid);
      end
      send(6, 7, 1);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'd68 || out_terms !== 5'd3) begin
         fails++;
         $display("FAIL gap_sum: v=%0d s=%0d t=%0d want 1/68/3",
                  out_valid, out_sum, out_terms);
      end
      idle(1);
   endtask

   task automatic test_wrap;
      send(255, 255, 0);
      send(255, 255, 1);
      tests++;
      if (out_sum !== 16'd64514 || out_terms !== 5'd2 || out_trunc !== 1'b0) begin
         fails++;
         $display("FAIL wrap_sum: s=%0d t=%0d tr=%0d want 64514/2/0",
                  out_sum, out_terms, out_trunc);
      end
      idle(1);
   endtask

   task automatic test_limit;
      for (int i = 0; i < 4; i++) send(1, 1, 0);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_terms !== 5'd4
          || out_trunc !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL limit_sum: v=%0d s=%0d t=%0d tr=%0d b=%0d want 1/4/4/1/0",
                  out_valid, out_sum, out_terms, out_trunc, busy);
      end
      send(1, 1, 0);
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL limit_next: b=%0d v=%0d want 1/0", busy, out_valid);
      end
      send(1, 1, 1);
      tests++;
      if (out_sum !== 16'd2 || out_terms !== 5'd2 || out_trunc !== 1'b0) begin
         fails++;
         $display("FAIL limit_tail: s=%0d t=%0d tr=%0d want 2/2/0",
                  out_sum, out_terms, out_trunc);
      end
      idle(1);
   endtask

   task automatic test_abort;
      send(3, 3, 0);
      send(3, 3, 0);
      @(negedge clk);
      in_valid = 1; in_ai = 9; in_xi = 9; in_last = 0; abort = 1;
      #1;
      tests++;
      if (in_ready !== 1'b0 || mac_ai !== 8'd0 || mac_last_input !== 1'b0) begin
         fails++;
         $display("FAIL abort_cycle: rdy=%0d ai=%0d last=%0d want 0/0/0",
                  in_ready, mac_ai, mac_last_input);
      end
      @(negedge clk);
      abort = 0; in_ai = 1; in_xi = 2; in_last = 1;
      #1;
      tests++;
      if (mac_last_input !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1
          || mac_ai !== 8'd0) begin
         fails++;
         $display("FAIL abort_flush: last=%0d rdy=%0d b=%0d ai=%0d want 1/0/1/0",
                  mac_last_input, in_ready, busy, mac_ai);
      end
      @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL abort_idle: b=%0d v=%0d rdy=%0d want 0/0/1",
                  busy, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'd2 || out_terms !== 5'd1) begin
         fails++;
         $display("FAIL abort_next: v=%0d s=%0d t=%0d want 1/2/1",
                  out_valid, out_sum, out_terms);
      end
      idle(1);
   endtask

   task automatic test_back_to_back;
      out_ready = 0;
      send(2, 3, 0);
      send(4, 5, 0);
      send(6, 7, 1);
      @(negedge clk);
      in_valid = 1; in_ai = 5; in_xi = 5; in_last = 1;
      #1;
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd68) begin
         fails++;
         $display("FAIL bp_stall: rdy=%0d v=%0d s=%0d want 0/1/68",
                  in_ready, out_valid, out_sum);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b0 || out_sum !== 16'd68) begin
         fails++;
         $display("FAIL bp_hold: rdy=%0d s=%0d want 0/68", in_ready, out_sum);
      end
      out_ready = 1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release: rdy=%0d want 1", in_ready);
      end
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'd25 || out_terms !== 5'd1) begin
         fails++;
         $display("FAIL bp_reload: v=%0d s=%0d t=%0d want 1/25/1",
                  out_valid, out_sum, out_terms);
      end
      idle(1);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_drain: v=%0d want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid;
      send(2, 3, 0);
      send(4, 5, 0);
      @(negedge clk);
      in_valid = 0; reset = 1;
      #1;
      tests++;
      if (busy !== 1'b0 || out_sum !== 16'd0 || out_terms !== '0
          || out_valid !== 1'b0 || mac_result !== 16'd0) begin
         fails++;
         $display("FAIL mid_reset: b=%0d s=%0d t=%0d v=%0d acc=%0d want 0",
                  busy, out_sum, out_terms, out_valid, mac_result);
      end
      @(negedge clk);
      reset = 0;
      send(1, 1, 0);
      send(2, 2, 1);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 16'd5 || out_terms !== 5'd2) begin
         fails++;
         $display("FAIL mid_after: v=%0d s=%0d t=%0d want 1/5/2",
                  out_valid, out_sum, out_terms);
      end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_wrap();
      test_limit();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
